// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
//   Shared defaults and helpers for the button_debounce block.
//   - DEF_WIDTH, DEF_DEBOUNCE_CYCLES, DEF_SYNC_STAGES : default parameters
//   - cnt_width(cycles) : counter width able to hold 0..cycles
// ---------------------------------------------------------------------------
package debounce_pkg;

  localparam int DEF_WIDTH           = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_SYNC_STAGES     = 2;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//   One input channel: SYNC_STAGES-flop synchroniser, stability counter,
//   debounced level and (optionally) registered rise/fall event pulses.
//   Optional feature macro: BUTTON_DEBOUNCE_EDGE_EN (edge pulse flops).
// Ports
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   ena    in  filter enable; 0 freezes counter/level and blanks pulses
//   din    in  raw asynchronous input
//   dout   out debounced level
//   rise   out 1-cycle pulse on dout 0->1 (0 when edge logic not built)
//   fall   out 1-cycle pulse on dout 1->0 (0 when edge logic not built)
// ---------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dout_q, dout_d;

  // Synchroniser free-runs regardless of ena so the filter always sees the
  // current pad level when it is re-enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (ena) begin
      if (s == dout_q) begin
        cnt_d = '0;
      end else if (cnt_q >= TERM) begin
        // Terminal count reached: accept the new level; >= keeps the counter
        // from ever wrapping even from an unexpected state.
        dout_d = s;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef BUTTON_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Pulses are registered on the same edge that updates dout, so they are
  // high exactly in the cycle dout has just changed. dout_d only differs
  // from dout_q while ena is high, which blanks pulses when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= dout_d & ~dout_q;
      fall_q <= ~dout_d & dout_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//   Synchronises and debounces WIDTH independent raw pad inputs. Each output
//   bit follows its input only after DEBOUNCE_CYCLES consecutive enabled
//   clocks of stable synchronised input.
//   Optional feature macro: BUTTON_DEBOUNCE_EDGE_EN (rise/fall pulses;
//   when undefined rise/fall are constant 0).
// Ports
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   ena    in  filter enable
//   din    in  [WIDTH] raw asynchronous inputs
//   dout   out [WIDTH] debounced levels
//   rise   out [WIDTH] 1-cycle pulse when dout goes 0->1
//   fall   out [WIDTH] 1-cycle pulse when dout goes 1->0
// ---------------------------------------------------------------------------
module button_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
      ) u_chan (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .din  (din[gi]),
        .dout (dout[gi]),
        .rise (rise[gi]),
        .fall (fall[gi])
      );
    end
  endgenerate

endmodule
